// File: rtl/utlb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : utlb_pkg
// Purpose  : Shared types for the micro-TLB: stored entry, FSM states and the
//            translation result bundle. Field widths follow the UTLB_*_W
//            constants, which are also the defaults of utlb_cache's width
//            parameters.
// Revision : 1.0  initial release
// ============================================================================
package utlb_pkg;

  localparam int UTLB_VPN_W  = 20;
  localparam int UTLB_PFN_W  = 20;
  localparam int UTLB_ASID_W = 8;

  typedef struct packed {
    logic                   valid;
    logic [UTLB_VPN_W-1:0]  vpn;
    logic [UTLB_ASID_W-1:0] asid;
    logic                   g;
    logic [UTLB_PFN_W-1:0]  pfn;
    logic                   d;
    logic                   c;
  } utlb_entry_t;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    LOOKUP      = 3'd1,
    REFILL_REQ  = 3'd2,
    REFILL_WAIT = 3'd3,
    RESP        = 3'd4
  } utlb_state_t;

  typedef struct packed {
    logic [UTLB_PFN_W-1:0] pfn;
    logic                  hit;
    logic                  valid_bit;
    logic                  dirty;
    logic                  cached;
    logic                  error;
  } utlb_result_t;

endpackage
`default_nettype wire

// File: rtl/utlb_victim_sel.sv
`default_nettype none
// ============================================================================
// Module   : utlb_victim_sel
// Purpose  : Chooses the entry a refill is written into: the lowest-index
//            invalid entry if any exists, otherwise the round-robin pointer.
// Ports    : clk, rst        - clock, synchronous active-high reset
//            valid_vec       - per-entry valid bits
//            install         - an install happens at the next edge
//            flush           - cache flush, pointer returns to 0
//            victim_idx      - selected entry
// Revision : 1.0  initial release
// ============================================================================
module utlb_victim_sel #(
  parameter int ENTRIES = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [ENTRIES-1:0]         valid_vec,
  input  logic                       install,
  input  logic                       flush,
  output logic [$clog2(ENTRIES)-1:0] victim_idx
);

  localparam int IDX_W = $clog2(ENTRIES);

  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] free_idx;
  logic             free_found;

  // Scan from the top down so the lowest free index wins.
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (!valid_vec[i]) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end
    victim_idx = free_found ? free_idx : rr_ptr;
  end

  // The pointer only moves when it actually supplied the victim; ENTRIES need
  // not be a power of two, so wrap explicitly.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rr_ptr <= '0;
    end else if (install && !free_found) begin
      rr_ptr <= (rr_ptr == IDX_W'(ENTRIES - 1)) ? '0 : rr_ptr + IDX_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/utlb_cache.sv
`default_nettype none
// ============================================================================
// Module   : utlb_cache
// Purpose  : Fully associative micro-TLB in front of the main TLB. Hits give
//            a registered translation one cycle after acceptance; misses run
//            a refill handshake, install good translations and forward every
//            main-TLB result (faults included) to the requester.
// Ports    : clk, rst                 - clock, synchronous active-high reset
//            req_valid/req_ready      - lookup request handshake
//            req_vpn, cur_asid        - page and ASID to translate
//            flush                    - invalidate all entries
//            resp_*                   - registered translation result pulse
//            tlb_req_*                - refill request to the main TLB
//            tlb_resp_*               - main-TLB result strobe and fields
// Revision : 1.0  initial release
// ============================================================================
module utlb_cache
  import utlb_pkg::*;
#(
  parameter int ENTRIES = 4,
  parameter int VPN_W   = UTLB_VPN_W,
  parameter int PFN_W   = UTLB_PFN_W,
  parameter int ASID_W  = UTLB_ASID_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [VPN_W-1:0]  req_vpn,
  input  logic [ASID_W-1:0] cur_asid,
  input  logic              flush,
  output logic              resp_valid,
  output logic [PFN_W-1:0]  resp_pfn,
  output logic              resp_hit,
  output logic              resp_valid_bit,
  output logic              resp_dirty,
  output logic              resp_cached,
  output logic              resp_error,
  output logic              tlb_req_valid,
  input  logic              tlb_req_ready,
  output logic [VPN_W-1:0]  tlb_req_vpn,
  input  logic              tlb_resp_valid,
  input  logic [PFN_W-1:0]  tlb_resp_pfn,
  input  logic              tlb_resp_hit,
  input  logic              tlb_resp_v,
  input  logic              tlb_resp_d,
  input  logic              tlb_resp_c,
  input  logic              tlb_resp_g,
  input  logic              tlb_resp_err
);

  localparam int IDX_W = $clog2(ENTRIES);

  utlb_state_t         state, state_nxt;
  utlb_entry_t         entries [ENTRIES];
  utlb_entry_t         hit_entry;
  utlb_result_t        resp_q;
  logic [ENTRIES-1:0]  match_vec;
  logic [ENTRIES-1:0]  valid_vec;
  logic [VPN_W-1:0]    lk_vpn;
  logic [ASID_W-1:0]   lk_asid;
  logic                lk_hit;
  logic                hit_now;
  logic                accept;
  logic                install;
  logic                refill_flushed;
  logic [IDX_W-1:0]    victim_idx;

  // Compare the incoming request so the translation can be registered at the
  // acceptance edge; LOOKUP then acts on the registered hit flag.
  generate
    for (genvar i = 0; i < ENTRIES; i++) begin : g_match
      assign valid_vec[i] = entries[i].valid;
      assign match_vec[i] = entries[i].valid && (entries[i].vpn == req_vpn) &&
                            (entries[i].g || (entries[i].asid == cur_asid));
    end
  endgenerate

  // At most one entry matches, so the last match found is the only one.
  always_comb begin
    hit_entry = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (match_vec[i]) hit_entry = entries[i];
    end
  end

  // A flush in the lookup cycle forces a miss.
  assign hit_now = (|match_vec) && !flush;
  assign accept  = req_valid && req_ready;

  // A flush seen while the refill is outstanding keeps the stale result out.
  assign install = (state == REFILL_WAIT) && tlb_resp_valid && tlb_resp_hit &&
                   tlb_resp_v && !tlb_resp_err && !refill_flushed && !flush;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    case (state)
      IDLE: begin
        req_ready = !rst;
        if (accept) state_nxt = LOOKUP;
      end
      LOOKUP: begin
        if (lk_hit) begin
          req_ready = !rst;
          state_nxt = accept ? LOOKUP : IDLE;
        end else begin
          state_nxt = REFILL_REQ;
        end
      end
      REFILL_REQ:  if (tlb_req_ready)  state_nxt = REFILL_WAIT;
      REFILL_WAIT: if (tlb_resp_valid) state_nxt = RESP;
      RESP:        state_nxt = IDLE;
      default:     state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lk_vpn         <= '0;
      lk_asid        <= '0;
      lk_hit         <= 1'b0;
      refill_flushed <= 1'b0;
      tlb_req_valid  <= 1'b0;
      tlb_req_vpn    <= '0;
      resp_valid     <= 1'b0;
      resp_q         <= '0;
    end else begin
      resp_valid <= 1'b0;
      if (accept) begin
        lk_vpn  <= req_vpn;
        lk_asid <= cur_asid;
        lk_hit  <= hit_now;
        if (hit_now) begin
          resp_valid <= 1'b1;
          resp_q     <= '{pfn: hit_entry.pfn, hit: 1'b1, valid_bit: 1'b1,
                          dirty: hit_entry.d, cached: hit_entry.c, error: 1'b0};
        end
      end
      if (state == LOOKUP && !lk_hit) begin
        tlb_req_valid  <= 1'b1;
        tlb_req_vpn    <= lk_vpn;
        refill_flushed <= 1'b0;
      end
      if (state == REFILL_REQ && tlb_req_ready) tlb_req_valid <= 1'b0;
      if ((state == REFILL_REQ || state == REFILL_WAIT) && flush)
        refill_flushed <= 1'b1;
      if (state == REFILL_WAIT && tlb_resp_valid) begin
        resp_valid <= 1'b1;
        resp_q     <= '{pfn: tlb_resp_pfn, hit: tlb_resp_hit, valid_bit: tlb_resp_v,
                        dirty: tlb_resp_d, cached: tlb_resp_c, error: tlb_resp_err};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      for (int i = 0; i < ENTRIES; i++) entries[i].valid <= 1'b0;
    end else if (install) begin
      entries[victim_idx] <= '{valid: 1'b1, vpn: lk_vpn, asid: lk_asid,
                               g: tlb_resp_g, pfn: tlb_resp_pfn,
                               d: tlb_resp_d, c: tlb_resp_c};
    end
  end

  utlb_victim_sel #(
    .ENTRIES (ENTRIES)
  ) u_victim_sel (
    .clk        (clk),
    .rst        (rst),
    .valid_vec  (valid_vec),
    .install    (install),
    .flush      (flush),
    .victim_idx (victim_idx)
  );

  assign resp_pfn       = resp_q.pfn;
  assign resp_hit       = resp_q.hit;
  assign resp_valid_bit = resp_q.valid_bit;
  assign resp_dirty     = resp_q.dirty;
  assign resp_cached    = resp_q.cached;
  assign resp_error     = resp_q.error;

endmodule
`default_nettype wire

// File: tb/tb_utlb_cache.sv
`default_nettype none
// ============================================================================
// Module   : tb_utlb_cache
// Purpose  : Scoreboard bench for utlb_cache. A page-table function stands in
//            for the main TLB; a small associative model predicts each
//            response, which a monitor compares as the DUT presents it.
// Revision : 1.0  initial release
// ============================================================================
module tb_utlb_cache;

  localparam int ENTRIES = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready;
  logic [19:0] req_vpn;
  logic [7:0]  cur_asid;
  logic        stim_flush, rsp_flush;
  wire         flush = stim_flush | rsp_flush;
  logic        resp_valid;
  logic [19:0] resp_pfn;
  logic        resp_hit, resp_valid_bit, resp_dirty, resp_cached, resp_error;
  logic        tlb_req_valid, tlb_req_ready;
  logic [19:0] tlb_req_vpn;
  logic        tlb_resp_valid;
  logic [19:0] tlb_resp_pfn;
  logic        tlb_resp_hit, tlb_resp_v, tlb_resp_d, tlb_resp_c, tlb_resp_g, tlb_resp_err;

  utlb_cache #(.ENTRIES(ENTRIES)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_vpn(req_vpn), .cur_asid(cur_asid), .flush(flush),
    .resp_valid(resp_valid), .resp_pfn(resp_pfn), .resp_hit(resp_hit),
    .resp_valid_bit(resp_valid_bit), .resp_dirty(resp_dirty),
    .resp_cached(resp_cached), .resp_error(resp_error),
    .tlb_req_valid(tlb_req_valid), .tlb_req_ready(tlb_req_ready),
    .tlb_req_vpn(tlb_req_vpn), .tlb_resp_valid(tlb_resp_valid),
    .tlb_resp_pfn(tlb_resp_pfn), .tlb_resp_hit(tlb_resp_hit),
    .tlb_resp_v(tlb_resp_v), .tlb_resp_d(tlb_resp_d), .tlb_resp_c(tlb_resp_c),
    .tlb_resp_g(tlb_resp_g), .tlb_resp_err(tlb_resp_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [19:0] pfn;
    logic hit, v, d, c, g, err;
  } pte_t;

  typedef struct {
    logic [19:0] pfn;
    logic hit, vb, d, c, err;
    int   cyc;   // negedge index the response must appear at, -1 = unchecked
  } exp_t;

  exp_t        exp_q[$];
  logic [19:0] ref_q[$];
  int          n_vec = 0, n_err = 0;
  int          neg_cnt = 0;
  int          exp_refills = 0, obs_refills = 0;
  logic        fast = 1'b1;
  logic        flush_in_wait = 1'b0;

  // Reference model: a plain associative array of translations.
  logic        m_valid [ENTRIES];
  logic [19:0] m_vpn   [ENTRIES];
  logic [7:0]  m_asid  [ENTRIES];
  logic        m_g     [ENTRIES];
  logic [19:0] m_pfn   [ENTRIES];
  logic        m_d     [ENTRIES];
  logic        m_c     [ENTRIES];
  int          m_ptr = 0;

  // Main-TLB contents. Faults only live in the 0x40-0x47 page range.
  function automatic pte_t pt(input logic [19:0] vpn);
    pte_t p;
    logic [31:0] h;
    h = {12'd0, vpn} * 32'd2654435761;
    if (vpn == 20'h00400) begin
      p.pfn = 20'h1F000; p.hit = 1; p.v = 1; p.d = 1; p.c = 1; p.g = 0; p.err = 0;
    end else begin
      p.pfn = h[31:12];
      p.hit = !(vpn[6] && vpn[0]);
      p.v   = !(vpn[6] && vpn[1] && !vpn[0]);
      p.err = vpn[6] && (vpn[2:0] == 3'b100);
      p.d   = h[3];
      p.c   = h[7];
      p.g   = vpn[5] || (vpn[3:0] == 4'h9);
    end
    return p;
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < ENTRIES; i++) m_valid[i] = 1'b0;
    m_ptr = 0;
  endfunction

  function automatic void model_accept(input logic [19:0] vpn, input logic [7:0] asid,
                                       input logic fl, input logic plan, input int snap);
    exp_t e;
    pte_t p;
    int   hi = -1;
    int   slot = -1;
    if (fl) model_clear();
    for (int i = 0; i < ENTRIES; i++)
      if (m_valid[i] && m_vpn[i] == vpn && (m_g[i] || m_asid[i] == asid)) hi = i;
    if (hi >= 0) begin
      e = '{m_pfn[hi], 1'b1, 1'b1, m_d[hi], m_c[hi], 1'b0, snap + 1};
    end else begin
      p = pt(vpn);
      e = '{p.pfn, p.hit, p.v, p.d, p.c, p.err, (fast && !plan) ? snap + 4 : -1};
      ref_q.push_back(vpn);
      exp_refills++;
      if (plan) begin
        model_clear();
        flush_in_wait = 1'b1;
      end else if (p.hit && p.v && !p.err) begin
        for (int i = 0; i < ENTRIES; i++) if (!m_valid[i] && slot < 0) slot = i;
        if (slot < 0) begin
          slot  = m_ptr;
          m_ptr = (m_ptr + 1) % ENTRIES;
        end
        m_valid[slot] = 1'b1; m_vpn[slot] = vpn; m_asid[slot] = asid;
        m_g[slot] = p.g; m_pfn[slot] = p.pfn; m_d[slot] = p.d; m_c[slot] = p.c;
      end
    end
    exp_q.push_back(e);
  endfunction

  // Monitor: pops the expected response whenever the DUT presents one.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      neg_cnt++;
      if (resp_valid) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL resp_unexpected: got pfn=%h with no response expected", resp_pfn);
        end else begin
          e = exp_q.pop_front();
          if ({resp_pfn, resp_hit, resp_valid_bit, resp_dirty, resp_cached, resp_error} !==
              {e.pfn, e.hit, e.vb, e.d, e.c, e.err}) begin
            n_err++;
            $display("FAIL resp_bundle: got pfn=%h h/v/d/c/e=%b%b%b%b%b expected pfn=%h h/v/d/c/e=%b%b%b%b%b",
                     resp_pfn, resp_hit, resp_valid_bit, resp_dirty, resp_cached, resp_error,
                     e.pfn, e.hit, e.vb, e.d, e.c, e.err);
          end
          if (e.cyc >= 0) begin
            n_vec++;
            if (neg_cnt != e.cyc) begin
              n_err++;
              $display("FAIL resp_latency: got cycle %0d expected cycle %0d", neg_cnt, e.cyc);
            end
          end
        end
      end
    end
  end

  // Main-TLB responder: random ready/latency, checks the refill vpn.
  initial begin
    logic [19:0] vpn;
    logic [19:0] ev;
    pte_t p;
    int   dly;
    tlb_req_ready = 1'b0; tlb_resp_valid = 1'b0; rsp_flush = 1'b0;
    tlb_resp_pfn = '0; tlb_resp_hit = 0; tlb_resp_v = 0; tlb_resp_d = 0;
    tlb_resp_c = 0; tlb_resp_g = 0; tlb_resp_err = 0;
    forever begin
      @(negedge clk);
      tlb_resp_valid = 1'b0;
      rsp_flush      = 1'b0;
      tlb_req_ready  = fast ? 1'b1 : 1'($urandom_range(0, 1));
      if (!rst && tlb_req_valid && tlb_req_ready) begin
        vpn = tlb_req_vpn;
        obs_refills++;
        n_vec++;
        if (ref_q.size() == 0) begin
          n_err++;
          $display("FAIL refill_unexpected: got refill vpn=%h with none expected", vpn);
        end else begin
          ev = ref_q.pop_front();
          if (ev !== vpn) begin
            n_err++;
            $display("FAIL refill_vpn: got %h expected %h", vpn, ev);
          end
        end
        dly = fast ? 0 : int'($urandom_range(0, 3));
        @(negedge clk);
        tlb_req_ready = 1'b0;
        rsp_flush     = flush_in_wait;
        repeat (dly) begin
          @(negedge clk);
          rsp_flush = 1'b0;
        end
        p = pt(vpn);
        tlb_resp_valid = 1'b1;
        tlb_resp_pfn = p.pfn; tlb_resp_hit = p.hit; tlb_resp_v = p.v;
        tlb_resp_d = p.d; tlb_resp_c = p.c; tlb_resp_g = p.g; tlb_resp_err = p.err;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // Holds the request until accepted; the model is updated at the accept edge.
  task automatic issue(input logic [19:0] vpn, input logic [7:0] asid,
                       input logic fl, input logic plan);
    int   waited = 0;
    int   snap;
    logic acc;
    logic fl_now;
    @(negedge clk);
    req_valid = 1'b1; req_vpn = vpn; cur_asid = asid; stim_flush = fl;
    fl_now = fl;
    forever begin
      #1;
      acc  = req_ready;
      snap = neg_cnt;
      @(posedge clk);
      if (acc) begin
        model_accept(vpn, asid, fl_now, plan, snap);
        break;
      end
      #1;
      stim_flush = 1'b0;
      fl_now     = 1'b0;
      waited++;
      if (waited > 400) begin
        n_vec++; n_err++;
        $display("FAIL accept_timeout: got no acceptance of vpn %h expected one", vpn);
        break;
      end
      @(negedge clk);
    end
    #1;
    req_valid = 1'b0; stim_flush = 1'b0;
  endtask

  task automatic drain();
    int waited = 0;
    while ((exp_q.size() != 0 || ref_q.size() != 0) && waited < 1000) begin
      @(negedge clk);
      waited++;
    end
    chk("drain", 32'(exp_q.size() + ref_q.size()), 32'd0);
    repeat (2) @(negedge clk);
    flush_in_wait = 1'b0;
  endtask

  logic [19:0] pick_vpn;

  initial begin
    model_clear();
    rst = 1'b1; req_valid = 1'b0; req_vpn = '0; cur_asid = '0; stim_flush = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_tlb_req_valid", 32'(tlb_req_valid), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
    chk("idle_req_ready", 32'(req_ready), 32'd1);

    // Cold miss then hit, with the fast main TLB for exact latencies.
    fast = 1'b1;
    issue(20'h00400, 8'd5, 1'b0, 1'b0);
    drain();
    issue(20'h00400, 8'd5, 1'b0, 1'b0);
    drain();
    fast = 1'b0;

    // Replacement wrap over a clean cache.
    issue(20'h1, 8'd5, 1'b1, 1'b0);
    for (int v = 2; v <= 6; v++) issue(20'(v), 8'd5, 1'b0, 1'b0);
    issue(20'h1, 8'd5, 1'b0, 1'b0);
    issue(20'h3, 8'd5, 1'b0, 1'b0);
    drain();

    // ASID and global entries.
    issue(20'h10, 8'd5, 1'b0, 1'b0);
    issue(20'h20, 8'd5, 1'b0, 1'b0);
    issue(20'h10, 8'd6, 1'b0, 1'b0);
    issue(20'h20, 8'd6, 1'b0, 1'b0);
    drain();

    // Faults are forwarded and re-probed.
    issue(20'h41, 8'd5, 1'b0, 1'b0);
    issue(20'h41, 8'd5, 1'b0, 1'b0);
    drain();

    // Flush during the refill wait, then prior hits must miss.
    issue(20'h2, 8'd5, 1'b0, 1'b0);
    issue(20'h30, 8'd5, 1'b0, 1'b1);
    drain();
    issue(20'h30, 8'd5, 1'b0, 1'b0);
    issue(20'h2, 8'd5, 1'b0, 1'b0);
    drain();

    // Randomised traffic.
    for (int n = 0; n < 300; n++) begin
      int r;
      pick_vpn = ($urandom_range(0, 2) == 0) ? 20'h40 + 20'($urandom_range(0, 7))
                                             : 20'($urandom_range(1, 10));
      r = int'($urandom_range(0, 99));
      if (r < 5) begin
        drain();
        issue(pick_vpn, 8'($urandom_range(5, 6)), 1'b1, 1'b0);
      end else if (r < 10) begin
        issue(pick_vpn, 8'($urandom_range(5, 6)), 1'b0, 1'b1);
        drain();
      end else if (r < 20) begin
        repeat ($urandom_range(1, 3)) @(negedge clk);
        issue(pick_vpn, 8'($urandom_range(5, 6)), 1'b0, 1'b0);
      end else begin
        issue(pick_vpn, 8'($urandom_range(5, 6)), 1'b0, 1'b0);
      end
    end
    drain();
    chk("refill_count", 32'(obs_refills), 32'(exp_refills));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
